// File: rtl/input_vc_route_buffer.sv
// rtl/input_vc_route_buffer.sv - per-input flit FIFO with head-flit XY route computation
module input_vc_route_buffer #(
   parameter int FLIT_W    = 8,
   parameter int FLIT_ID_W = 2,
   parameter int OUT_M     = 5,
   parameter int BUF_DEPTH = 4,
   parameter int X_W       = 2,
   parameter int Y_W       = 2,
   parameter int COL_CORD  = 0,
   parameter int ROW_CORD  = 0
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [FLIT_W-1:0]          data_i,
   input  logic                       wr_en_i,
   output logic                       rdy_o,
   output logic [FLIT_W-1:0]          data_o,
   output logic [FLIT_ID_W-1:0]       flit_id_o,
   output logic                       data_vld_o,
   output logic [$clog2(OUT_M)-1:0]   rtr_res_o,
   output logic                       rtr_res_vld_o,
   input  logic                       chan_alloc_i,
   output logic                       err_o
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int RES_W = $clog2(OUT_M);

   localparam logic [FLIT_ID_W-1:0] ID_HEAD   = FLIT_ID_W'(1);
   localparam logic [FLIT_ID_W-1:0] ID_TAIL   = FLIT_ID_W'(2);
   localparam logic [FLIT_ID_W-1:0] ID_SINGLE = FLIT_ID_W'(3);

   localparam logic [X_W-1:0] COL_C = X_W'(COL_CORD);
   localparam logic [Y_W-1:0] ROW_C = Y_W'(ROW_CORD);

   localparam logic [RES_W-1:0] OUT_LOCAL = RES_W'(0);
   localparam logic [RES_W-1:0] OUT_NORTH = RES_W'(1);
   localparam logic [RES_W-1:0] OUT_EAST  = RES_W'(2);
   localparam logic [RES_W-1:0] OUT_SOUTH = RES_W'(3);
   localparam logic [RES_W-1:0] OUT_WEST  = RES_W'(4);

   typedef enum logic {ST_IDLE, ST_ROUTED} state_t;

   logic [FLIT_W-1:0] r_mem [BUF_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   state_t            r_state;
   state_t            w_state_nxt;
   logic [RES_W-1:0]  r_route;
   logic [RES_W-1:0]  w_route;
   logic              r_err;

   logic              w_empty;
   logic              w_full;
   logic              w_wr;
   logic              w_rd;
   logic              w_pop;
   logic              w_orphan;
   logic              w_route_ld;
   logic              w_head_starts;
   logic              w_head_ends;
   logic [FLIT_W-1:0] w_head;
   logic [FLIT_ID_W-1:0] w_head_id;
   logic [X_W-1:0]    w_dest_x;
   logic [Y_W-1:0]    w_dest_y;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_W'(BUF_DEPTH));
   assign w_head    = r_mem[r_rd_ptr];
   assign w_head_id = w_head[FLIT_W-1 -: FLIT_ID_W];
   assign w_dest_x  = w_head[X_W-1:0];
   assign w_dest_y  = w_head[X_W+Y_W-1:X_W];

   assign w_head_starts = (w_head_id == ID_HEAD) || (w_head_id == ID_SINGLE);
   assign w_head_ends   = (w_head_id == ID_TAIL) || (w_head_id == ID_SINGLE);

   assign w_wr = wr_en_i && !w_full;
   assign w_rd = w_pop || w_orphan;

   assign rdy_o         = !w_full;
   assign data_o        = w_head;
   assign flit_id_o     = w_head_id;
   assign data_vld_o    = (r_state == ST_ROUTED) && !w_empty;
   assign rtr_res_vld_o = (r_state == ST_ROUTED);
   assign rtr_res_o     = r_route;
   assign err_o         = r_err;

   // X is resolved fully before Y (dimension-ordered routing).
   always_comb begin
      w_route = OUT_LOCAL;
      if (w_dest_x > COL_C) begin
         w_route = OUT_EAST;
      end else if (w_dest_x < COL_C) begin
         w_route = OUT_WEST;
      end else if (w_dest_y > ROW_C) begin
         w_route = OUT_SOUTH;
      end else if (w_dest_y < ROW_C) begin
         w_route = OUT_NORTH;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_route_ld  = 1'b0;
      w_orphan    = 1'b0;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!w_empty) begin
               if (w_head_starts) begin
                  w_route_ld  = 1'b1;
                  w_state_nxt = ST_ROUTED;
               end else begin
                  w_orphan = 1'b1;
               end
            end
         end
         ST_ROUTED: begin
            if (chan_alloc_i && !w_empty) begin
               w_pop = 1'b1;
               if (w_head_ends) begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state  <= ST_IDLE;
         r_route  <= '0;
         r_err    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_err   <= w_orphan;
         if (w_route_ld) begin
            r_route <= w_route;
         end
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is not reset; the occupancy count alone qualifies its contents.
   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

endmodule

// File: tb/tb_input_vc_route_buffer.sv
// tb/tb_input_vc_route_buffer.sv - randomized and directed bench for input_vc_route_buffer
module tb_input_vc_route_buffer;

   localparam int FLIT_W = 8;
   localparam int DEPTH  = 4;
   localparam int COL    = 1;
   localparam int ROW    = 1;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic [FLIT_W-1:0] data_i;
   logic             wr_en_i;
   logic             rdy_o;
   logic [FLIT_W-1:0] data_o;
   logic [1:0]       flit_id_o;
   logic             data_vld_o;
   logic [2:0]       rtr_res_o;
   logic             rtr_res_vld_o;
   logic             chan_alloc_i;
   logic             err_o;

   input_vc_route_buffer #(
      .FLIT_W(FLIT_W), .FLIT_ID_W(2), .OUT_M(5), .BUF_DEPTH(DEPTH),
      .X_W(2), .Y_W(2), .COL_CORD(COL), .ROW_CORD(ROW)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .wr_en_i(wr_en_i),
      .rdy_o(rdy_o), .data_o(data_o), .flit_id_o(flit_id_o),
      .data_vld_o(data_vld_o), .rtr_res_o(rtr_res_o),
      .rtr_res_vld_o(rtr_res_vld_o), .chan_alloc_i(chan_alloc_i), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] m_q[$];
   bit         m_routed;
   int         m_route;
   bit         m_err;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int xy_route(input logic [7:0] f);
      int x = int'(f[1:0]);
      int y = int'(f[3:2]);
      if (x > COL) return 2;
      if (x < COL) return 4;
      if (y > ROW) return 3;
      if (y < ROW) return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_routed = 0;
      m_route  = 0;
      m_err    = 0;
   endtask

   // Advance the reference one clock using the state seen before the edge.
   task automatic model_step(input bit wr, input logic [7:0] din, input bit al);
      bit        has = (m_q.size() > 0);
      logic [1:0] id = has ? m_q[0][7:6] : 2'b00;
      bit        vld = m_routed && has;
      bit        pop = al && vld;
      bit        orphan = !m_routed && has && (id == 2'b00 || id == 2'b10);
      bit        start  = !m_routed && has && (id == 2'b01 || id == 2'b11);
      bit        wr_ok  = wr && (m_q.size() < DEPTH);
      m_err = orphan;
      if (start) begin
         m_route  = xy_route(m_q[0]);
         m_routed = 1;
      end
      if (pop && (id == 2'b10 || id == 2'b11)) m_routed = 0;
      if (pop || orphan) void'(m_q.pop_front());
      if (wr_ok) m_q.push_back(din);
   endtask

   task automatic compare_all();
      chk("rdy",      32'(rdy_o),         32'(m_q.size() < DEPTH));
      chk("data_vld", 32'(data_vld_o),    32'(m_routed && m_q.size() > 0));
      chk("rtr_vld",  32'(rtr_res_vld_o), 32'(m_routed));
      chk("rtr_res",  32'(rtr_res_o),     32'(m_route));
      chk("err",      32'(err_o),         32'(m_err));
      if (m_q.size() > 0) begin
         chk("data_o",  32'(data_o),    32'(m_q[0]));
         chk("flit_id", 32'(flit_id_o), 32'(m_q[0][7:6]));
      end
   endtask

   task automatic cycle(input bit wr, input logic [7:0] din, input bit al);
      wr_en_i      = wr;
      data_i       = din;
      chan_alloc_i = al;
      @(posedge clk_i);
      model_step(wr, din, al);
      #1;
      compare_all();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rdy"},  32'(rdy_o),         32'd1);
      chk({tag, "_vld"},  32'(data_vld_o),    32'd0);
      chk({tag, "_rvld"}, 32'(rtr_res_vld_o), 32'd0);
      chk({tag, "_res"},  32'(rtr_res_o),     32'd0);
      chk({tag, "_err"},  32'(err_o),         32'd0);
   endtask

   initial begin
      rst_ni       = 1'b0;
      wr_en_i      = 1'b0;
      data_i       = '0;
      chan_alloc_i = 1'b0;
      model_reset();
      #22;
      check_reset_outputs("reset");
      rst_ni = 1'b1;
      compare_all();

      for (int i = 0; i < 10; i++) cycle(0, 8'h00, 0);

      // East-bound 3-flit packet with grant held
      cycle(1, 8'h43, 1);
      chk("east_pre_rvld", 32'(rtr_res_vld_o), 32'd0);
      cycle(1, 8'h00, 1);
      chk("east_rvld", 32'(rtr_res_vld_o), 32'd1);
      chk("east_res",  32'(rtr_res_o),     32'd2);
      cycle(1, 8'h80, 1);
      for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1);
      chk("east_done_rvld", 32'(rtr_res_vld_o), 32'd0);

      // Single-flit packets: local, north, west
      cycle(1, 8'hC5, 1);
      cycle(1, 8'hC1, 1);
      cycle(1, 8'hC8, 1);
      for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1);

      // Fill past full with grant withheld
      cycle(1, 8'h46, 0);
      cycle(1, 8'h01, 0);
      cycle(1, 8'h02, 0);
      cycle(1, 8'h03, 0);
      chk("full_rdy", 32'(rdy_o), 32'd0);
      cycle(1, 8'h04, 0);
      cycle(0, 8'h00, 0);
      cycle(0, 8'h00, 1);
      chk("after_pop_rdy", 32'(rdy_o), 32'd1);
      cycle(1, 8'h05, 0);
      chk("refull_rdy", 32'(rdy_o), 32'd0);
      // Write and pop together while full: the write is dropped
      cycle(1, 8'h3F, 1);
      cycle(1, 8'h80, 0);
      for (int i = 0; i < 8; i++) cycle(0, 8'h00, 1);

      // Orphan body flit into an idle buffer
      cycle(1, 8'h05, 0);
      cycle(0, 8'h00, 0);
      chk("orphan_err", 32'(err_o), 32'd1);
      cycle(0, 8'h00, 0);
      chk("orphan_err_clr", 32'(err_o), 32'd0);
      for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0);

      // Asynchronous reset in the middle of a packet
      cycle(1, 8'h43, 0);
      cycle(1, 8'h00, 0);
      cycle(0, 8'h00, 0);
      #2;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      wr_en_i = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      compare_all();

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         logic [7:0] f;
         f = 8'($urandom);
         cycle(($urandom_range(0, 3) != 0), f, ($urandom_range(0, 2) != 0));
      end
      for (int i = 0; i < 12; i++) cycle(0, 8'h00, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
